// File: rtl/tdm_mux8.sv
// 8:1 time-division multiplexer: captures one 8-bit word and streams it onto Y,
// one channel per clock, with gapless back-to-back frames when LOAD stays high.
module tdm_mux8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       CLK,
  input  logic       N_RESET,
  input  logic [7:0] X,
  input  logic       LOAD,
  output logic       READY,
  output logic       Y,
  output logic [2:0] SEL,
  output logic       VALID,
  output logic       LAST
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] FINAL_IDX = MSB_FIRST ? 3'd0 : 3'd7;

  state_e     state_q, state_d;
  logic [7:0] hold_q,  hold_d;
  logic [2:0] sel_q,   sel_d;
  logic       y_q,     y_d;
  logic [2:0] sel_step;

  assign VALID = (state_q == SEND);
  assign LAST  = VALID && (sel_q == FINAL_IDX);
  assign READY = !VALID || LAST;
  assign SEL   = sel_q;
  assign Y     = y_q;

  assign sel_step = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);

  // NOTE: every next-state signal gets a default first so no path through
  // this block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    y_d     = y_q;
    if (READY && LOAD) begin
      state_d = SEND;
      hold_d  = X;
      sel_d   = START_IDX;
      y_d     = X[START_IDX];
    end else if (state_q == SEND && !LAST) begin
      sel_d = sel_step;
      y_d   = hold_q[sel_step];
    end else if (state_q == SEND) begin
      // Final bit sent with no new word waiting: drop back to a quiet idle bus.
      state_d = IDLE;
      sel_d   = 3'd0;
      y_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from pre-edge values, matching the hardware flops.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= IDLE;
      hold_q  <= 8'h00;
      sel_q   <= 3'd0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux8.sv
// Directed self-checking bench for tdm_mux8; an LSB-first and an MSB-first
// instance share the same stimulus.
module tb_tdm_mux8;

  logic       CLK;
  logic       N_RESET;
  logic [7:0] X;
  logic       LOAD;

  logic       ready_l, y_l, valid_l, last_l;
  logic [2:0] sel_l;
  logic       ready_m, y_m, valid_m, last_m;
  logic [2:0] sel_m;

  int checks;
  int failures;

  tdm_mux8 #(.MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .N_RESET(N_RESET), .X(X), .LOAD(LOAD),
    .READY(ready_l), .Y(y_l), .SEL(sel_l), .VALID(valid_l), .LAST(last_l)
  );

  tdm_mux8 #(.MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .N_RESET(N_RESET), .X(X), .LOAD(LOAD),
    .READY(ready_m), .Y(y_m), .SEL(sel_m), .VALID(valid_m), .LAST(last_m)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid_l"}, {7'd0, valid_l}, 8'd0);
    check({tag, "_sel_l"},   {5'd0, sel_l},   8'd0);
    check({tag, "_y_l"},     {7'd0, y_l},     8'd0);
    check({tag, "_ready_l"}, {7'd0, ready_l}, 8'd1);
    check({tag, "_last_l"},  {7'd0, last_l},  8'd0);
  endtask

  // Hand-computed serial sequences for X = 8'b1010_0110.
  logic y_lsb_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic y_msb_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    checks   = 0;
    failures = 0;
    N_RESET  = 1'b0;
    LOAD     = 1'b0;
    X        = 8'h00;

    // Reset state, and idle outputs ignore X.
    #2;
    X = 8'hFF;
    #1;
    check_idle("reset");
    check("reset_ready_m", {7'd0, ready_m}, 8'd1);
    tick();
    tick();
    N_RESET = 1'b1;
    tick();
    check_idle("idle_x_ff");

    // Single word, both orders.
    X    = 8'b1010_0110;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    X    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single_valid_l_%0d", i), {7'd0, valid_l}, 8'd1);
      check($sformatf("single_sel_l_%0d", i),   {5'd0, sel_l},   8'(i));
      check($sformatf("single_y_l_%0d", i),     {7'd0, y_l},     {7'd0, y_lsb_exp[i]});
      check($sformatf("single_last_l_%0d", i),  {7'd0, last_l},  (i == 7) ? 8'd1 : 8'd0);
      check($sformatf("single_sel_m_%0d", i),   {5'd0, sel_m},   8'(7 - i));
      check($sformatf("single_y_m_%0d", i),     {7'd0, y_m},     {7'd0, y_msb_exp[i]});
      check($sformatf("single_last_m_%0d", i),  {7'd0, last_m},  (i == 7) ? 8'd1 : 8'd0);
      tick();
    end
    check_idle("single_end");
    check("single_end_valid_m", {7'd0, valid_m}, 8'd0);
    check("single_end_sel_m",   {5'd0, sel_m},   8'd0);

    // Back-to-back frames with LOAD held high.
    X    = 8'hFF;
    LOAD = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_valid_%0d", i), {7'd0, valid_l}, 8'd1);
      check($sformatf("b2b_y_%0d", i),     {7'd0, y_l},     (i < 8) ? 8'd1 : 8'd0);
      check($sformatf("b2b_sel_%0d", i),   {5'd0, sel_l},   8'(i % 8));
      check($sformatf("b2b_ready_%0d", i), {7'd0, ready_l}, (i % 8 == 7) ? 8'd1 : 8'd0);
      if (i == 7)  X    = 8'h00;
      if (i == 15) LOAD = 1'b0;
      tick();
    end
    check_idle("b2b_end");

    // Mid-frame LOAD and X changes are ignored.
    X    = 8'hF0;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ign_sel_%0d", i), {5'd0, sel_l}, 8'(i));
      check($sformatf("ign_y_%0d", i),   {7'd0, y_l},   (i >= 4) ? 8'd1 : 8'd0);
      if (i == 3) begin
        LOAD = 1'b1;
        X    = 8'h00;
      end else begin
        LOAD = 1'b0;
      end
      tick();
    end
    check_idle("ign_end");

    // Mid-frame reset aborts the frame.
    X    = 8'hFF;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    repeat (4) tick();
    check("mrst_sel_before", {5'd0, sel_l}, 8'd4);
    #1;
    N_RESET = 1'b0;
    #1;
    check_idle("mrst_async");
    tick();
    tick();
    N_RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mrst_after_valid_%0d", i), {7'd0, valid_l}, 8'd0);
      check($sformatf("mrst_after_y_%0d", i),     {7'd0, y_l},     8'd0);
    end

    // First edge after reset release accepts a load.
    N_RESET = 1'b0;
    #1;
    N_RESET = 1'b1;
    X    = 8'h01;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    check("post_rst_valid", {7'd0, valid_l}, 8'd1);
    check("post_rst_sel",   {5'd0, sel_l},   8'd0);
    check("post_rst_y",     {7'd0, y_l},     8'd1);
    repeat (8) tick();
    check_idle("post_rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
